fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory port plus the control inputs
// and IF/ID outputs exchanged with the rest of the pipeline.
interface fetch_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_valid;
    logic [5:0]            opcode;
    logic [ADDR_WIDTH-1:0] pc_plus1;

    // Fetch unit side.
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, inst, inst_pc, inst_valid, opcode, pc_plus1
    );

    // Pipeline / memory side.
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, inst, inst_pc, inst_valid, opcode, pc_plus1
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous ROM. Keeps the next
// fetch address, the address/validity of the word currently on the ROM
// data bus, and the IF/ID pipeline register. Redirects beat stalls and
// insert exactly one bubble; stalls re-present the in-flight address so
// the ROM output stays put.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [5:0]            NOP_OPCODE = 6'b111111
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  fetch_v_q;
    logic [31:0]           inst_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic                  inst_valid_q;

    // ROM address select: redirect target first, then the held address
    // during a stall, otherwise the sequential next address.
    // NOTE: every output of an always_comb is assigned on every path
    // (here via the final else); a missing branch would infer a latch.
    always_comb begin
        if (bus.redirect) begin
            bus.imem_addr = bus.redirect_pc;
        end else if (bus.stall) begin
            bus.imem_addr = fetch_pc_q;
        end else begin
            bus.imem_addr = pc_q;
        end
    end

    // PC, in-flight fetch tracking and IF/ID register update.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, matching hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            fetch_v_q    <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else if (bus.redirect) begin
            // Discard the word on the ROM bus; the target is being
            // fetched this edge, so IF/ID takes one bubble.
            pc_q         <= bus.redirect_pc + ADDR_WIDTH'(1);
            fetch_pc_q   <= bus.redirect_pc;
            fetch_v_q    <= 1'b1;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            // Wraps naturally at 2^ADDR_WIDTH.
            pc_q         <= pc_q + ADDR_WIDTH'(1);
            fetch_pc_q   <= pc_q;
            fetch_v_q    <= 1'b1;
            inst_q       <= bus.imem_rdata;
            inst_pc_q    <= fetch_pc_q;
            inst_valid_q <= fetch_v_q;
        end
    end

    // IF/ID outputs; the opcode is masked to a NOP whenever the slot is empty.
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.opcode     = inst_valid_q ? inst_q[31:26] : NOP_OPCODE;
    assign bus.pc_plus1   = inst_pc_q + ADDR_WIDTH'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (RESET_PC 0 and 0xFE)
// fed by behavioural synchronous ROMs. Expected IF/ID contents are queued
// as each cycle's stimulus is issued and compared after the edge.
module tb_fetch_unit;

    localparam logic [5:0] NOP = 6'b111111;

    typedef struct packed {
        logic        valid;
        logic [7:0]  pc;
        logic [31:0] inst;
        logic [5:0]  op;
        logic [7:0]  p1;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];

    fetch_if #(.ADDR_WIDTH(8)) bus0 ();
    fetch_if #(.ADDR_WIDTH(8)) bus1 ();

    fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .NOP_OPCODE(NOP)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'hFE), .NOP_OPCODE(NOP)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: dut0 sees mem[i]=i, dut1 also carries i[5:0] in the opcode field.
    function automatic logic [31:0] rom0(input logic [7:0] a);
        return {24'h0, a};
    endfunction
    function automatic logic [31:0] rom1(input logic [7:0] a);
        return {a[5:0], 18'h0, a};
    endfunction

    always @(posedge clk) begin
        bus0.imem_rdata <= rom0(bus0.imem_addr);
        bus1.imem_rdata <= rom1(bus1.imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_valid(input logic [7:0] p, input logic [31:0] w, input logic [5:0] op);
        exp_t e;
        e.valid = 1'b1;
        e.pc    = p;
        e.inst  = w;
        e.op    = op;
        e.p1    = p + 8'd1;
        return e;
    endfunction

    function automatic exp_t mk_bubble();
        exp_t e;
        e = '0;
        e.op = NOP;
        return e;
    endfunction

    task automatic push0(input logic [7:0] p);
        q0.push_back(mk_valid(p, rom0(p), 6'h00));
    endtask
    task automatic push1(input logic [7:0] p);
        q1.push_back(mk_valid(p, rom1(p), p[5:0]));
    endtask

    task automatic compare(input string tag, input exp_t e, input logic v,
                           input logic [7:0] pc, input logic [31:0] inst,
                           input logic [5:0] op, input logic [7:0] p1);
        check({tag, "_valid"}, 32'(v), 32'(e.valid));
        check({tag, "_opcode"}, 32'(op), 32'(e.op));
        if (e.valid) begin
            check({tag, "_pc"}, 32'(pc), 32'(e.pc));
            check({tag, "_inst"}, inst, e.inst);
            check({tag, "_pc_plus1"}, 32'(p1), 32'(e.p1));
        end
    endtask

    // Drive one cycle of stimulus to dut0, clock it, then score both DUTs.
    task automatic cycle(input string tag, input logic s, input logic r, input logic [7:0] rpc);
        exp_t e;
        bus0.stall       = s;
        bus0.redirect    = r;
        bus0.redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
        if (q0.size() == 0) begin
            check({tag, "_sb0_empty"}, 32'(q0.size()), 32'd1);
        end else begin
            e = q0.pop_front();
            compare({tag, "_d0"}, e, bus0.inst_valid, bus0.inst_pc, bus0.inst,
                    bus0.opcode, bus0.pc_plus1);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            compare({tag, "_d1"}, e, bus1.inst_valid, bus1.inst_pc, bus1.inst,
                    bus1.opcode, bus1.pc_plus1);
        end
    endtask

    // Reset release: bubble, then RESET_PC onwards for both instances.
    task automatic restart(input string tag);
        rst_n = 1'b1;
        q0.push_back(mk_bubble());
        q1.push_back(mk_bubble());
        cycle({tag, "_e1"}, 1'b0, 1'b0, 8'h00);
        push1(8'hFE);
        push1(8'hFF);
        push1(8'h00);
        for (int p = 0; p < 4; p++) begin
            push0(8'(p));
            cycle({tag, "_seq"}, 1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.stall = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = '0;
        bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_valid", 32'(bus0.inst_valid), 32'd0);
        check("rst_opcode", 32'(bus0.opcode), 32'(NOP));
        check("rst_inst", bus0.inst, 32'd0);
        check("rst_inst_pc", 32'(bus0.inst_pc), 32'd0);
        check("rst_addr0", 32'(bus0.imem_addr), 32'h00);
        check("rst_addr1", 32'(bus1.imem_addr), 32'hFE);
        check("rst_opcode1", 32'(bus1.opcode), 32'(NOP));

        // Straight-line fetch from reset (pc 0..3), continue to 4.
        restart("boot");
        push0(8'd4);
        cycle("seq4", 1'b0, 1'b0, 8'h00);

        // Three-cycle stall with inst_pc=4: IF/ID holds, ROM address stays 5.
        for (int i = 0; i < 3; i++) begin
            bus0.stall = 1'b1;
            #1;
            check("stall_addr", 32'(bus0.imem_addr), 32'd5);
            push0(8'd4);
            cycle("stall_hold", 1'b1, 1'b0, 8'h00);
            check("stall_addr_post", 32'(bus0.imem_addr), 32'd5);
        end
        for (int p = 5; p < 8; p++) begin
            push0(8'(p));
            cycle("post_stall", 1'b0, 1'b0, 8'h00);
        end

        // Redirect to 0x40 while inst_pc=7.
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 8'h40;
        #1;
        check("redir_addr", 32'(bus0.imem_addr), 32'h40);
        q0.push_back(mk_bubble());
        cycle("redir_bubble", 1'b0, 1'b1, 8'h40);
        push0(8'h40);
        cycle("redir_tgt", 1'b0, 1'b0, 8'h00);
        push0(8'h41);
        cycle("redir_next", 1'b0, 1'b0, 8'h00);

        // Redirect with stall asserted: redirect wins.
        q0.push_back(mk_bubble());
        cycle("rs_bubble", 1'b1, 1'b1, 8'h20);
        push0(8'h20);
        cycle("rs_tgt", 1'b0, 1'b0, 8'h00);
        push0(8'h21);
        cycle("rs_next", 1'b0, 1'b0, 8'h00);

        // Back-to-back redirects: the last target wins.
        q0.push_back(mk_bubble());
        cycle("rr_first", 1'b0, 1'b1, 8'h80);
        q0.push_back(mk_bubble());
        cycle("rr_second", 1'b0, 1'b1, 8'h90);
        push0(8'h90);
        cycle("rr_tgt", 1'b0, 1'b0, 8'h00);
        push0(8'h91);
        cycle("rr_next", 1'b0, 1'b0, 8'h00);

        // Get to inst_pc=9, stall, then reset mid-stall.
        q0.push_back(mk_bubble());
        cycle("to8", 1'b0, 1'b1, 8'h08);
        push0(8'h08);
        cycle("at8", 1'b0, 1'b0, 8'h00);
        push0(8'h09);
        cycle("at9", 1'b0, 1'b0, 8'h00);
        push0(8'h09);
        cycle("stall9", 1'b1, 1'b0, 8'h00);

        bus0.stall = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus0.inst_valid), 32'd0);
        check("arst_inst", bus0.inst, 32'd0);
        check("arst_inst_pc", 32'(bus0.inst_pc), 32'd0);
        check("arst_opcode", 32'(bus0.opcode), 32'(NOP));
        check("arst_addr", 32'(bus0.imem_addr), 32'h00);
        // Reset must also dominate a redirect across a clock edge.
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 8'h55;
        @(posedge clk);
        @(negedge clk);
        check("rst_redir_valid", 32'(bus0.inst_valid), 32'd0);
        check("rst_redir_pc", 32'(bus0.inst_pc), 32'd0);
        bus0.redirect = 1'b0;
        bus0.stall = 1'b0;
        #1;
        check("rst_redir_addr", 32'(bus0.imem_addr), 32'h00);

        restart("reboot");

        check("sb0_drained", 32'(q0.size()), 32'd0);
        check("sb1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
